// File: rtl/paddle_match_ctrl.sv
// Match sequencer and input controller for the two-paddle game.
// Debounces the raw buttons and drives the active-low paddle move commands,
// either from the players or from a simple ball-tracking CPU. It also runs
// the match state machine, gates the ball, recentres the paddles and keeps
// the score.
module paddle_match_ctrl #(
    parameter int DEBOUNCE_MS  = 8,
    parameter int SERVE_MS     = 1000,
    parameter int POINT_MS     = 1500,
    parameter int WIN_SCORE    = 7,
    parameter int CPU_DEADBAND = 4,
    parameter int CPU_DIV      = 2
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       start_n,
    input  logic [3:0] btn_n,
    input  logic [1:0] cpu_en,
    input  logic [9:0] y_ball,
    input  logic [9:0] y_paddle1,
    input  logic [9:0] y_paddle2,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] cmd_n,
    output logic       paddle_rst_n,
    output logic       ball_run,
    output logic [2:0] state,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner
);

    localparam int DB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int DIV_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam logic signed [10:0] DEADBAND_S = 11'(CPU_DEADBAND);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Bit 0 is the start button, bits 4:1 are the player buttons.
    logic [4:0] raw_n;
    logic [4:0] db_n;
    logic [3:0] btn_db_n;
    assign raw_n    = {btn_n, start_n};
    assign btn_db_n = db_n[4:1];

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
            logic            db_q;
            logic [DB_W-1:0] cnt_q;
            // Adopt the raw level only after DEBOUNCE_MS consecutive disagreeing samples
            always_ff @(posedge clk_1ms) begin
                if (!reset) begin
                    db_q  <= 1'b1;
                    cnt_q <= '0;
                end else if (raw_n[gi] == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_W'(DEBOUNCE_MS - 1)) begin
                    db_q  <= raw_n[gi];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign db_n[gi] = db_q;
        end
    endgenerate

    logic             start_prev_q;
    logic             start_press;
    logic [DIV_W-1:0] div_q;

    // Edge history for the start button and the shared CPU move divider
    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            start_prev_q <= 1'b1;
            div_q        <= '0;
        end else begin
            start_prev_q <= db_n[0];
            div_q        <= (div_q == DIV_W'(CPU_DIV - 1)) ? '0 : div_q + 1'b1;
        end
    end

    assign start_press = start_prev_q & ~db_n[0];

    // Per-player command pair {down_n, up_n} before state gating.
    logic [3:0] player_cmd;
    logic [9:0] y_pad_arr [2];
    assign y_pad_arr[0] = y_paddle1;
    assign y_pad_arr[1] = y_paddle2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            logic signed [10:0] diff;
            logic               up_db_n;
            logic               dn_db_n;
            logic [1:0]         pair;
            assign diff    = $signed({1'b0, y_ball}) - $signed({1'b0, y_pad_arr[gi]});
            assign up_db_n = btn_db_n[2*gi];
            assign dn_db_n = btn_db_n[2*gi+1];
            // CPU chases the ball outside the deadband; humans follow debounced buttons
            always_comb begin
                pair = 2'b11;
                if (cpu_en[gi]) begin
                    if (div_q == '0) begin
                        if (diff > DEADBAND_S) begin
                            pair[1] = 1'b0;
                        end else if (diff < -DEADBAND_S) begin
                            pair[0] = 1'b0;
                        end
                    end
                end else if (up_db_n | dn_db_n) begin
                    pair = {dn_db_n, up_db_n};
                end
            end
            assign player_cmd[2*gi +: 2] = pair;
        end
    endgenerate

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic [1:0]  winner_q, winner_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        prst_q, prst_d;
    logic        run_q, run_d;

    // Match sequencing, scoring, and per-state outputs derived from the current state
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_d  = S_SERVE;
                    timer_d  = 16'(SERVE_MS - 1);
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = 2'b00;
                end
            end
            S_SERVE: begin
                if (timer_q == '0) begin
                    state_d = S_PLAY;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_PLAY: begin
                // Simultaneous misses cancel out.
                if (miss_right ^ miss_left) begin
                    if (miss_right) begin
                        score1_d = score1_q + 4'd1;
                    end else begin
                        score2_d = score2_q + 4'd1;
                    end
                    if (score1_d == 4'(WIN_SCORE) || score2_d == 4'(WIN_SCORE)) begin
                        state_d  = S_OVER;
                        winner_d = miss_right ? 2'b01 : 2'b10;
                    end else begin
                        state_d = S_POINT;
                        timer_d = 16'(POINT_MS - 1);
                    end
                end
            end
            S_POINT: begin
                if (timer_q == '0) begin
                    state_d = S_SERVE;
                    timer_d = 16'(SERVE_MS - 1);
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        prst_d = (state_q == S_SERVE) || (state_q == S_PLAY) || (state_q == S_OVER);
        run_d  = (state_q == S_PLAY);
        cmd_d  = ((state_q == S_SERVE) || (state_q == S_PLAY)) ? player_cmd : 4'hF;
    end

    // Match state, timer, score and registered outputs
    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= 2'b00;
            cmd_q    <= 4'hF;
            prst_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            cmd_q    <= cmd_d;
            prst_q   <= prst_d;
            run_q    <= run_d;
        end
    end

    assign state        = state_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign winner       = winner_q;
    assign cmd_n        = cmd_q;
    assign paddle_rst_n = prst_q;
    assign ball_run     = run_q;

endmodule

// File: tb/tb_paddle_match_ctrl.sv
// Scoreboard bench for paddle_match_ctrl: the stimulus process queues
// expected output values tagged with the clock-edge number they must hold
// after; a monitor samples on the falling edge and retires due entries.
module tb_paddle_match_ctrl;

    logic       clk_1ms = 1'b0;
    logic       reset = 1'b0;
    logic       start_n = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic [1:0] cpu_en = 2'b00;
    logic [9:0] y_ball = 10'd512;
    logic [9:0] y_paddle1 = 10'd512;
    logic [9:0] y_paddle2 = 10'd512;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic [3:0] cmd_n;
    logic       paddle_rst_n;
    logic       ball_run;
    logic [2:0] state;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;

    paddle_match_ctrl dut (
        .clk_1ms     (clk_1ms),
        .reset       (reset),
        .start_n     (start_n),
        .btn_n       (btn_n),
        .cpu_en      (cpu_en),
        .y_ball      (y_ball),
        .y_paddle1   (y_paddle1),
        .y_paddle2   (y_paddle2),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .cmd_n       (cmd_n),
        .paddle_rst_n(paddle_rst_n),
        .ball_run    (ball_run),
        .state       (state),
        .score1      (score1),
        .score2      (score2),
        .winner      (winner)
    );

    always #5 clk_1ms = ~clk_1ms;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk_1ms) cyc <= cyc + 1;

    localparam int SIG_STATE = 0;
    localparam int SIG_S1    = 1;
    localparam int SIG_S2    = 2;
    localparam int SIG_WIN   = 3;
    localparam int SIG_CMD   = 4;
    localparam int SIG_PRST  = 5;
    localparam int SIG_RUN   = 6;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int rst_cyc = 0;

    function automatic int actual(int sig);
        case (sig)
            SIG_STATE: return int'(state);
            SIG_S1:    return int'(score1);
            SIG_S2:    return int'(score2);
            SIG_WIN:   return int'(winner);
            SIG_CMD:   return int'(cmd_n);
            SIG_PRST:  return int'(paddle_rst_n);
            default:   return int'(ball_run);
        endcase
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            SIG_STATE: return "state";
            SIG_S1:    return "score1";
            SIG_S2:    return "score2";
            SIG_WIN:   return "winner";
            SIG_CMD:   return "cmd_n";
            SIG_PRST:  return "paddle_rst_n";
            default:   return "ball_run";
        endcase
    endfunction

    // Monitor: retire every expectation due after the current edge.
    always @(negedge clk_1ms) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                int a;
                a = actual(sb[i].sig);
                checks++;
                if (sb[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s stale expectation for edge %0d seen at edge %0d", sig_name(sb[i].sig), sb[i].cyc, cyc);
                end else if (a != sb[i].val) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %0d expected %0d", sig_name(sb[i].sig), cyc, a, sb[i].val);
                end else begin
                    $display("check %s edge %0d = %0d ok", sig_name(sb[i].sig), cyc, a);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int c, input int sig, input int val);
        exp_t e;
        e.cyc = c;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_1ms);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // CPU command expected after edge e: a move only when the divider was 0
    // on the previous cycle (divider cleared by the reset edge rst_cyc).
    function automatic int cpu_cmd(input int e, input int move_val);
        return (((e - 1 - rst_cyc) % 2) == 0) ? move_val : 15;
    endfunction

    initial begin
        int b;
        // Reset
        tick(3);
        rst_cyc = cyc;
        reset = 1'b1;
        expect_at(cyc, SIG_STATE, 0);
        expect_at(cyc, SIG_S1, 0);
        expect_at(cyc, SIG_S2, 0);
        expect_at(cyc, SIG_WIN, 0);
        expect_at(cyc, SIG_CMD, 15);
        expect_at(cyc, SIG_PRST, 0);
        expect_at(cyc, SIG_RUN, 0);
        tick(2);

        // Start sequence
        b = cyc;
        start_n = 1'b0;
        expect_at(b + 8, SIG_STATE, 0);
        expect_at(b + 9, SIG_STATE, 1);
        expect_at(b + 9, SIG_PRST, 0);
        expect_at(b + 10, SIG_PRST, 1);
        expect_at(b + 1008, SIG_STATE, 1);
        expect_at(b + 1009, SIG_STATE, 2);
        expect_at(b + 1009, SIG_RUN, 0);
        expect_at(b + 1010, SIG_RUN, 1);
        tick(12);
        start_n = 1'b1;
        wait_until(b + 1015);

        // Debounce: short glitch is rejected
        b = cyc;
        btn_n = 4'b1110;
        for (int d = 1; d <= 14; d++) expect_at(b + d, SIG_CMD, 15);
        tick(5);
        btn_n = 4'hF;
        tick(10);
        // Held press appears one cycle after the debounced change
        b = cyc;
        btn_n = 4'b1110;
        expect_at(b + 8, SIG_CMD, 15);
        expect_at(b + 9, SIG_CMD, 14);
        expect_at(b + 20, SIG_CMD, 14);
        tick(22);
        // Up and down together cancel
        b = cyc;
        btn_n = 4'b1100;
        expect_at(b + 8, SIG_CMD, 14);
        expect_at(b + 9, SIG_CMD, 15);
        tick(12);
        btn_n = 4'hF;
        tick(12);
        // Down alone
        b = cyc;
        btn_n = 4'b1101;
        expect_at(b + 9, SIG_CMD, 13);
        tick(12);
        btn_n = 4'hF;
        tick(12);

        // CPU tracking on P2: ball below paddle, move down on divider cycles
        b = cyc;
        cpu_en = 2'b10;
        y_ball = 10'd300;
        y_paddle2 = 10'd240;
        for (int e = b + 1; e <= b + 8; e++) expect_at(e, SIG_CMD, cpu_cmd(e, 7));
        tick(10);
        // diff = 4: inside deadband
        b = cyc;
        y_paddle2 = 10'd296;
        for (int e = b + 1; e <= b + 6; e++) expect_at(e, SIG_CMD, 15);
        tick(8);
        // diff = 5: just outside deadband
        b = cyc;
        y_paddle2 = 10'd295;
        for (int e = b + 1; e <= b + 4; e++) expect_at(e, SIG_CMD, cpu_cmd(e, 7));
        tick(6);
        // Ball above paddle, raw P2 buttons pressed and ignored
        b = cyc;
        y_ball = 10'd100;
        btn_n = 4'b0011;
        for (int e = b + 1; e <= b + 20; e++) expect_at(e, SIG_CMD, cpu_cmd(e, 11));
        tick(22);
        btn_n = 4'hF;
        tick(12);
        cpu_en = 2'b00;
        y_ball = 10'd512;
        y_paddle2 = 10'd512;
        expect_at(cyc + 2, SIG_CMD, 15);
        tick(4);

        // Point flow: P1 scores, commands gated during the pause
        b = cyc;
        miss_right = 1'b1;
        expect_at(b + 1, SIG_STATE, 3);
        expect_at(b + 1, SIG_S1, 1);
        expect_at(b + 1, SIG_PRST, 1);
        expect_at(b + 2, SIG_PRST, 0);
        expect_at(b + 2, SIG_RUN, 0);
        expect_at(b + 2, SIG_CMD, 15);
        expect_at(b + 100, SIG_CMD, 15);
        expect_at(b + 1500, SIG_STATE, 3);
        expect_at(b + 1500, SIG_CMD, 15);
        expect_at(b + 1501, SIG_STATE, 1);
        expect_at(b + 1502, SIG_PRST, 1);
        expect_at(b + 1502, SIG_CMD, 14);
        expect_at(b + 1609, SIG_CMD, 15);
        expect_at(b + 2500, SIG_STATE, 1);
        expect_at(b + 2501, SIG_STATE, 2);
        tick(1);
        miss_right = 1'b0;
        btn_n = 4'b1110;
        wait_until(b + 1600);
        btn_n = 4'hF;
        wait_until(b + 2505);

        // Simultaneous misses are ignored
        b = cyc;
        miss_left = 1'b1;
        miss_right = 1'b1;
        expect_at(b + 1, SIG_STATE, 2);
        expect_at(b + 1, SIG_S1, 1);
        expect_at(b + 1, SIG_S2, 0);
        expect_at(b + 3, SIG_STATE, 2);
        expect_at(b + 3, SIG_RUN, 1);
        tick(1);
        miss_left = 1'b0;
        miss_right = 1'b0;
        tick(3);

        // Game over: P2 takes seven points
        for (int i = 1; i <= 7; i++) begin
            b = cyc;
            miss_left = 1'b1;
            expect_at(b + 1, SIG_S2, i);
            if (i < 7) begin
                expect_at(b + 1, SIG_STATE, 3);
                expect_at(b + 1, SIG_WIN, 0);
            end else begin
                expect_at(b + 1, SIG_STATE, 4);
                expect_at(b + 1, SIG_WIN, 2);
                expect_at(b + 1, SIG_S1, 1);
                expect_at(b + 2, SIG_RUN, 0);
                expect_at(b + 2, SIG_PRST, 1);
                expect_at(b + 2, SIG_CMD, 15);
            end
            tick(1);
            miss_left = 1'b0;
            if (i < 7) wait_until(b + 2505);
        end
        tick(3);
        // Misses in OVER are ignored
        b = cyc;
        miss_right = 1'b1;
        expect_at(b + 1, SIG_STATE, 4);
        expect_at(b + 1, SIG_S1, 1);
        tick(1);
        miss_right = 1'b0;
        tick(3);
        // Restart from OVER
        b = cyc;
        start_n = 1'b0;
        expect_at(b + 8, SIG_STATE, 4);
        expect_at(b + 9, SIG_STATE, 1);
        expect_at(b + 9, SIG_S1, 0);
        expect_at(b + 9, SIG_S2, 0);
        expect_at(b + 9, SIG_WIN, 0);
        expect_at(b + 1009, SIG_STATE, 2);
        tick(12);
        start_n = 1'b1;
        wait_until(b + 1015);

        // Bring score1 to 3, then reset mid-match
        for (int j = 1; j <= 3; j++) begin
            b = cyc;
            miss_right = 1'b1;
            expect_at(b + 1, SIG_S1, j);
            expect_at(b + 1, SIG_STATE, 3);
            tick(1);
            miss_right = 1'b0;
            wait_until(b + 2505);
        end
        b = cyc;
        btn_n = 4'b1110;
        expect_at(b + 9, SIG_CMD, 14);
        expect_at(b + 12, SIG_STATE, 2);
        tick(12);
        b = cyc;
        reset = 1'b0;
        expect_at(b + 1, SIG_STATE, 0);
        expect_at(b + 1, SIG_S1, 0);
        expect_at(b + 1, SIG_S2, 0);
        expect_at(b + 1, SIG_WIN, 0);
        expect_at(b + 1, SIG_CMD, 15);
        expect_at(b + 1, SIG_PRST, 0);
        expect_at(b + 1, SIG_RUN, 0);
        expect_at(b + 3, SIG_STATE, 0);
        tick(1);
        reset = 1'b1;
        btn_n = 4'hF;
        tick(5);

        // Drain the scoreboard with a bound
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
